ir_convolver: RTL and testbench



---
 rtl/ir_convolver.sv | 212 +++++++++++++++++++++
 tb/tb_ir_convolver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_convolver.sv
// ---------------------------------------------------------------------------
// ir_convolver
//
// Time-multiplexed FIR engine. It convolves the guitar sample stream with a
// TAPS-long cabinet impulse response using one multiplier and one
// accumulator. Each accepted sample triggers one pass over all taps.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   weights     [TAPS-1:0][WIDTH-1:0] signed Q1.15 IR coefficients
//   in_valid    in_sample is valid
//   in_ready    block can accept a sample (IDLE only)
//   in_sample   signed input sample
//   out_valid   out_sample is valid (OUT state)
//   out_ready   downstream accepts out_sample
//   out_sample  signed convolved sample, held stable while out_valid
//
// Build option:
//   IR_CONVOLVER_SATURATE_EN  defined   -> the shifted accumulator is clamped
//                                          to the WIDTH-bit signed range
//                             undefined -> the low WIDTH bits are taken
//                                          (two's-complement wrap)
//
// Timing: the sample is accepted at edge T. The history read and the
// weight are registered on each MAC cycle, so the last product is added
// one cycle after MAC ends (DRAIN). out_valid rises at edge T+TAPS+1.
// ---------------------------------------------------------------------------
module ir_convolver #(
  parameter int TAPS      = 256,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [TAPS-1:0][WIDTH-1:0]   weights,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sample
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  logic [AW-1:0]               r_k;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               w_rd_addr;
  logic [AW-1:0]               w_wr_ptr_inc;
  logic                        w_accept;
  logic                        w_last_tap;

  logic [WIDTH-1:0]            r_hist [TAPS];
  logic signed [WIDTH-1:0]     r_h_q;
  logic signed [WIDTH-1:0]     r_w_q;
  logic                        r_p_valid;

  logic signed [2*WIDTH-1:0]   w_w_ext;
  logic signed [2*WIDTH-1:0]   w_h_ext;
  logic signed [2*WIDTH-1:0]   w_mul;
  logic signed [ACC_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_acc_sum;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic [WIDTH-1:0]            w_result;
  logic [WIDTH-1:0]            r_out_sample;

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_last_tap = (r_k == AW'(TAPS - 1));

  // Newest sample sits at wr_ptr, tap k reads the sample k steps older.
  // Adding TAPS on underflow keeps the index correct for any TAPS.
  assign w_rd_addr = r_wr_ptr - r_k + ((r_wr_ptr < r_k) ? AW'(TAPS) : '0);

  assign w_wr_ptr_inc = (r_wr_ptr == AW'(TAPS - 1)) ? '0 : r_wr_ptr + AW'(1);

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = MAC;
        end
      end
      MAC: begin
        if (w_last_tap) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sample history. Cleared on reset so an aborted run leaves no residue.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_accept) begin
      r_hist[r_wr_ptr] <= in_sample;
    end
  end

  // -------------------------------------------------------------------------
  // Multiply-accumulate datapath
  // -------------------------------------------------------------------------
  assign w_w_ext   = {{WIDTH{r_w_q[WIDTH-1]}}, r_w_q};
  assign w_h_ext   = {{WIDTH{r_h_q[WIDTH-1]}}, r_h_q};
  assign w_mul     = w_w_ext * w_h_ext;
  assign w_prod    = {{(ACC_WIDTH-2*WIDTH){w_mul[2*WIDTH-1]}}, w_mul};
  assign w_acc_sum = r_acc + w_prod;
  assign w_shift   = w_acc_sum >>> FRAC_BITS;

`ifdef IR_CONVOLVER_SATURATE_EN
  logic w_in_range;

  // In range when every bit from the output sign bit upward agrees.
  assign w_in_range = (&w_shift[ACC_WIDTH-1:WIDTH-1]) | ~(|w_shift[ACC_WIDTH-1:WIDTH-1]);

  always_comb begin
    w_result = w_shift[WIDTH-1:0];
    if (!w_in_range) begin
      w_result = w_shift[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic w_unused_bits;

  assign w_result      = w_shift[WIDTH-1:0];
  assign w_unused_bits = ^w_shift[ACC_WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_wr_ptr     <= '0;
      r_acc        <= '0;
      r_h_q        <= '0;
      r_w_q        <= '0;
      r_p_valid    <= 1'b0;
      r_out_sample <= '0;
    end else begin
      // A registered operand pair is consumed one cycle after it is read.
      r_p_valid <= (r_state == MAC);

      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
      end else if (r_p_valid) begin
        r_acc <= w_acc_sum;
      end

      if (r_state == MAC) begin
        r_h_q <= r_hist[w_rd_addr];
        r_w_q <= weights[r_k];
        r_k   <= r_k + AW'(1);
        if (w_last_tap) begin
          r_wr_ptr <= w_wr_ptr_inc;
        end
      end

      // DRAIN adds the final product and captures the result in one step.
      if (r_state == DRAIN) begin
        r_out_sample <= w_result;
      end
    end
  end

  assign out_sample = r_out_sample;

endmodule

// File: tb/tb_ir_convolver.sv
// ---------------------------------------------------------------------------
// tb_ir_convolver
//
// Scoreboard bench for ir_convolver. Stimulus pushes the expected output
// when a sample is accepted; a monitor pops and compares on each output
// handshake. Covers reset state, saturation/wrap, reset mid-MAC, latency,
// backpressure and a full impulse response including history wrap.
// ---------------------------------------------------------------------------
module tb_ir_convolver;

  localparam int TAPS  = 256;
  localparam int WIDTH = 16;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [TAPS-1:0][WIDTH-1:0] weights;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_sample;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_sample;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               id_q[$];
  logic [WIDTH-1:0] prod_ir [TAPS];

  ir_convolver #(
    .TAPS(TAPS), .WIDTH(WIDTH), .ACC_WIDTH(40), .FRAC_BITS(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .weights    (weights),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  // After active edge X, cyc == X.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic [WIDTH-1:0] e;
    int               id;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%04h, required no output", out_sample);
        end else begin
          e  = exp_q.pop_front();
          id = id_q.pop_front();
          $display("out[%0d] = 0x%04h (expected 0x%04h)", id, out_sample, e);
          check($sformatf("out[%0d]", id), 32'(out_sample), 32'(e));
        end
      end
    end
  end

  // --------------------------------------------------------------- watchdog
  initial begin
    #950000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------------ tasks
  task automatic send(input logic [WIDTH-1:0] s, input int id, input logic [WIDTH-1:0] e,
                      input bit push, output longint t_acc);
    int n;
    n = 0;
    @(negedge clk);
    in_sample = s;
    in_valid  = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d]: got in_ready=0, required 1 within 2000 cycles", id);
      in_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    @(posedge clk);
    if (push) begin
      exp_q.push_back(e);
      id_q.push_back(id);
    end
    @(negedge clk);
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
      exp_q.delete();
      id_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_all_weights(input logic [WIDTH-1:0] w);
    for (int i = 0; i < TAPS; i++) weights[i] = w;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    longint           t;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] held;
    int               p;
    int               ov_first, ov_cnt, ir_first, d;
    int               n;
    bit               bp_valid_ok, bp_data_ok, bp_ready_ok, seen_valid;

    // Production IR table: arbitrary small values, with the taps the
    // impulse test calls out pinned to their known coefficients.
    for (int i = 0; i < TAPS; i++) prod_ir[i] = 16'(((i * 97) % 513) - 256);
    prod_ir[0] = 16'h0519;
    prod_ir[1] = 16'h0B13;
    prod_ir[7] = 16'hFF08;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    set_all_weights(16'h7FFF);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_in_ready",   32'(in_ready),   32'd1);
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_out_sample", 32'(out_sample), 32'd0);
    rst_n = 1'b1;

    // Saturation / wrap, positive: 0x7FFF*0x7FFF>>15 = 0x7FFE, twice = 0xFFFC raw
    send(16'h7FFF, 0, 16'h7FFE, 1'b1, t);
`ifdef IR_CONVOLVER_SATURATE_EN
    e = 16'h7FFF;
`else
    e = 16'hFFFC;
`endif
    send(16'h7FFF, 1, e, 1'b1, t);
    wait_drain();

    // Saturation / wrap, negative, from fresh history
    do_reset();
    send(16'h8000, 2, 16'h8001, 1'b1, t);
`ifdef IR_CONVOLVER_SATURATE_EN
    e = 16'h8000;
`else
    e = 16'h0002;
`endif
    send(16'h8000, 3, e, 1'b1, t);
    wait_drain();

    // Reset at MAC cycle 100: no output for the aborted sample
    send(16'h7FFF, -1, 16'h0000, 1'b0, t);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready",   32'(in_ready),   32'd1);
    check("abort_out_valid",  32'(out_valid),  32'd0);
    check("abort_out_sample", 32'(out_sample), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("abort_no_output", 32'(seen_valid), 32'd0);

    // Impulse response with the production table
    for (int i = 0; i < TAPS; i++) weights[i] = prod_ir[i];
    for (int k = 0; k < TAPS + 2; k++) begin
      s = (k == 0) ? 16'h7FFF : 16'h0000;
      if (k == 0) e = 16'h0518;
      else if (k == 1) e = 16'h0B12;
      else if (k == 7) e = 16'hFF08;
      else if (k >= TAPS) e = 16'h0000;
      else begin
        p = $signed(prod_ir[k]) * 32767;
        e = 16'(p >>> 15);
      end

      send(s, 100 + k, e, 1'b1, t);

      if (k == 0) begin
        // Latency / handshake on the first accept
        ov_first = -1;
        ov_cnt   = 0;
        ir_first = -1;
        for (int j = 0; j <= 260; j++) begin
          d = int'(cyc - t);
          if (out_valid) begin
            if (ov_first < 0) ov_first = d;
            ov_cnt++;
          end
          if (in_ready && ir_first < 0) ir_first = d;
          @(negedge clk);
        end
        check("latency_out_valid_rise", 32'(ov_first), 32'd257);
        check("latency_out_valid_len",  32'(ov_cnt),   32'd1);
        check("latency_in_ready_rise",  32'(ir_first), 32'd258);
      end

      if (k == 3) begin
        // Backpressure: hold out_ready low for 20 cycles of out_valid
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("bp_out_valid_rise", 32'(out_valid), 32'd1);
        held        = out_sample;
        bp_valid_ok = 1'b1;
        bp_data_ok  = 1'b1;
        bp_ready_ok = 1'b1;
        for (int j = 0; j < 20; j++) begin
          if (!out_valid) bp_valid_ok = 1'b0;
          if (out_sample !== held) bp_data_ok = 1'b0;
          if (in_ready) bp_ready_ok = 1'b0;
          in_valid  = j[0] ? 1'b0 : 1'b1;
          in_sample = 16'h1234;
          @(negedge clk);
        end
        in_valid  = 1'b0;
        in_sample = '0;
        check("bp_out_valid_held",  32'(bp_valid_ok), 32'd1);
        check("bp_out_sample_held", 32'(bp_data_ok),  32'd1);
        check("bp_in_ready_low",    32'(bp_ready_ok), 32'd1);
        out_ready = 1'b1;
      end
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
